pdm_multi_mod: RTL and testbench

// - Multi-channel, time-multiplexed sigma-delta PDM modulator with selectable order (1st/2nd), one channel per clk.
// - Accepts packed signed PCM frames via valid/ready; emits one PDM bit per channel per rising edge of sample_in.
// - Sits between the PCM/beamformer output and the PDM DAC/loopback pins, sharing one noise-shaper datapath.

---
 rtl/pdm_pkg.sv | 43 ++++
 rtl/pdm_shaper_core.sv | 37 +++
 rtl/pdm_multi_mod.sv | 177 +++++++++++++++++
 tb/tb_pdm_multi_mod.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// Shared types and arithmetic helpers for the multi-channel PDM modulator.
package pdm_pkg;

    typedef enum logic {
        ORD1 = 1'b0,
        ORD2 = 1'b1
    } order_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // First integrator carries two guard bits above the sample width.
    function automatic int w1_of(input int bw);
        return bw + 2;
    endfunction

    // Second integrator accumulates the first, so it needs two more bits.
    function automatic int w2_of(input int bw);
        return bw + 4;
    endfunction

    // Full-scale feedback magnitude for a signed sample of width bw.
    function automatic logic signed [63:0] fs_of(input int bw);
        return 64'sd1 <<< (bw - 1);
    endfunction

    // Clamp v to the signed range of a w-bit value; never wraps.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        return v;
    endfunction

endpackage

// File: rtl/pdm_shaper_core.sv
// Combinational noise-shaper update for one channel slot.
module pdm_shaper_core
    import pdm_pkg::*;
#(
    parameter int  BIT_WIDTH = 24,
    localparam int W1        = w1_of(BIT_WIDTH),
    localparam int W2        = w2_of(BIT_WIDTH)
) (
    input  logic signed [BIT_WIDTH-1:0] x,
    input  logic signed [W1-1:0]        i1,
    input  logic signed [W2-1:0]        i2,
    input  logic                        y_prev,
    input  order_e                      order,
    output logic signed [W1-1:0]        i1_nxt,
    output logic signed [W2-1:0]        i2_nxt,
    output logic                        y
);

    logic signed [63:0] fb;
    logic signed [63:0] s1;
    logic signed [63:0] s2;

    // Integrate error against the previous bit's feedback; quantize the last stage's sign.
    always_comb begin
        fb     = y_prev ? fs_of(BIT_WIDTH) : -fs_of(BIT_WIDTH);
        s1     = sat_s(64'(i1) + 64'(x) - fb, W1);
        s2     = sat_s(64'(i2) + s1 - fb, W2);
        i1_nxt = s1[W1-1:0];
        i2_nxt = i2;
        y      = (s1 >= 64'sd0);
        if (order == ORD2) begin
            i2_nxt = s2[W2-1:0];
            y      = (s2 >= 64'sd0);
        end
    end

endmodule

// File: rtl/pdm_multi_mod.sv
// Time-multiplexed multi-channel sigma-delta PDM modulator, one channel per clock.
module pdm_multi_mod
    import pdm_pkg::*;
#(
    parameter int  BIT_WIDTH = 24,
    parameter int  NUM_CH    = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        sample_in,
    input  logic                        order_in,
    input  logic [NUM_CH-1:0]           ch_en_in,
    input  logic [NUM_CH*BIT_WIDTH-1:0] audio_in,
    input  logic                        audio_valid_in,
    output logic                        audio_ready_out,
    output logic [NUM_CH-1:0]           pdm_out,
    output logic                        frame_done_out,
    output logic                        overrun_out
);

    localparam int W1 = w1_of(BIT_WIDTH);
    localparam int W2 = w2_of(BIT_WIDTH);

    logic                        sample_prev;
    logic                        tick;
    logic                        tick_idle;
    logic                        xfer;
    logic [NUM_CH*BIT_WIDTH-1:0] pend_q;
    logic [NUM_CH*BIT_WIDTH-1:0] act_q;
    logic                        pend_full_q;
    state_e                      state_q;
    state_e                      state_d;
    logic [CH_W-1:0]             ch_q;
    logic [CH_W-1:0]             ch_d;
    order_e                      ord_q;
    order_e                      ord_new;
    logic [NUM_CH-1:0][W1-1:0]   i1_q;
    logic [NUM_CH-1:0][W2-1:0]   i2_q;
    logic [NUM_CH-1:0]           yp_q;
    logic [NUM_CH-1:0]           shadow_q;

    logic signed [BIT_WIDTH-1:0] core_x;
    logic signed [W1-1:0]        core_i1;
    logic signed [W2-1:0]        core_i2;
    logic signed [W1-1:0]        core_i1_nxt;
    logic signed [W2-1:0]        core_i2_nxt;
    logic                        core_y;

    assign tick            = sample_in & ~sample_prev;
    assign tick_idle       = tick && (state_q == ST_IDLE);
    assign xfer            = audio_valid_in & ~pend_full_q;
    assign audio_ready_out = ~pend_full_q;
    assign ord_new         = order_e'(order_in);

    assign core_x  = act_q[ch_q*BIT_WIDTH +: BIT_WIDTH];
    assign core_i1 = i1_q[ch_q];
    assign core_i2 = i2_q[ch_q];

    pdm_shaper_core #(
        .BIT_WIDTH(BIT_WIDTH)
    ) u_core (
        .x      (core_x),
        .i1     (core_i1),
        .i2     (core_i2),
        .y_prev (yp_q[ch_q]),
        .order  (ord_q),
        .i1_nxt (core_i1_nxt),
        .i2_nxt (core_i2_nxt),
        .y      (core_y)
    );

    // Oversample clock edge detector; tracks the level in every state.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in)
            sample_prev <= 1'b0;
        else
            sample_prev <= sample_in;
    end

    // Two-deep sample buffer: a new word lands in pending, the tick promotes it to active.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            pend_q      <= '0;
            act_q       <= '0;
            pend_full_q <= 1'b0;
        end else begin
            if (tick_idle && pend_full_q)
                act_q <= pend_q;
            if (xfer) begin
                pend_q      <= audio_in;
                pend_full_q <= 1'b1;
            end else if (tick_idle && pend_full_q) begin
                pend_full_q <= 1'b0;
            end
        end
    end

    // Frame sequencer state register.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    // Frame sequencer: start on tick, walk every channel, then publish.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_RUN;
                    ch_d    = '0;
                end
            end
            ST_RUN: begin
                if (ch_q == CH_W'(NUM_CH - 1))
                    state_d = ST_DONE;
                else
                    ch_d = ch_q + 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-channel shaper state; an order switch flushes every channel so the loops restart clean.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            ord_q    <= ORD1;
            i1_q     <= '0;
            i2_q     <= '0;
            yp_q     <= '0;
            shadow_q <= '0;
        end else if (tick_idle) begin
            ord_q <= ord_new;
            if (ord_new != ord_q) begin
                i1_q <= '0;
                i2_q <= '0;
                yp_q <= '0;
            end
        end else if (state_q == ST_RUN) begin
            if (ch_en_in[ch_q]) begin
                i1_q[ch_q]     <= core_i1_nxt;
                i2_q[ch_q]     <= core_i2_nxt;
                yp_q[ch_q]     <= core_y;
                shadow_q[ch_q] <= core_y;
            end else begin
                i1_q[ch_q]     <= '0;
                i2_q[ch_q]     <= '0;
                yp_q[ch_q]     <= 1'b0;
                shadow_q[ch_q] <= 1'b0;
            end
        end
    end

    // Output bits update together at frame end; overrun is sticky until reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            pdm_out        <= '0;
            frame_done_out <= 1'b0;
            overrun_out    <= 1'b0;
        end else begin
            frame_done_out <= (state_q == ST_DONE);
            if (state_q == ST_DONE)
                pdm_out <= shadow_q;
            if (tick && (state_q != ST_IDLE))
                overrun_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pdm_multi_mod.sv
// Self-checking bench for pdm_multi_mod against a frame-level arithmetic model.
module tb_pdm_multi_mod;

    localparam int     BW   = 24;
    localparam int     NCH  = 4;
    localparam longint FS   = 64'sd1 <<< (BW - 1);
    localparam longint MAX1 = 4 * FS - 1;
    localparam longint MAX2 = 16 * FS - 1;

    logic                clk_in = 1'b0;
    logic                rst_n_in = 1'b0;
    logic                sample_in = 1'b0;
    logic                order_in = 1'b0;
    logic [NCH-1:0]      ch_en_in = '1;
    logic [NCH*BW-1:0]   audio_in = '0;
    logic                audio_valid_in = 1'b0;
    logic                audio_ready_out;
    logic [NCH-1:0]      pdm_out;
    logic                frame_done_out;
    logic                overrun_out;

    int n_chk = 0;
    int n_pass = 0;

    longint            m_i1 [NCH];
    longint            m_i2 [NCH];
    bit                m_y  [NCH];
    bit                m_ord;
    logic [NCH*BW-1:0] m_act;
    logic [NCH*BW-1:0] m_pend [$];

    pdm_multi_mod #(.BIT_WIDTH(BW), .NUM_CH(NCH)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .sample_in       (sample_in),
        .order_in        (order_in),
        .ch_en_in        (ch_en_in),
        .audio_in        (audio_in),
        .audio_valid_in  (audio_valid_in),
        .audio_ready_out (audio_ready_out),
        .pdm_out         (pdm_out),
        .frame_done_out  (frame_done_out),
        .overrun_out     (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic longint clampw(input longint v, input longint hi);
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_i1[c] = 0; m_i2[c] = 0; m_y[c] = 0;
        end
        m_ord = 0;
        m_act = '0;
        m_pend.delete();
    endtask

    // One accepted tick: promote pending, flush on order change, then shape every channel.
    task automatic model_tick(input bit ord, input logic [NCH-1:0] en, output logic [NCH-1:0] exp_bits);
        logic signed [BW-1:0] s;
        longint x, fb;
        if (m_pend.size() > 0) m_act = m_pend.pop_front();
        if (ord != m_ord)
            for (int c = 0; c < NCH; c++) begin
                m_i1[c] = 0; m_i2[c] = 0; m_y[c] = 0;
            end
        m_ord = ord;
        for (int c = 0; c < NCH; c++) begin
            if (!en[c]) begin
                m_i1[c] = 0; m_i2[c] = 0; m_y[c] = 0;
            end else begin
                s  = m_act[c*BW +: BW];
                x  = longint'(s);
                fb = m_y[c] ? FS : -FS;
                m_i1[c] = clampw(m_i1[c] + x - fb, MAX1);
                if (ord) begin
                    m_i2[c] = clampw(m_i2[c] + m_i1[c] - fb, MAX2);
                    m_y[c]  = (m_i2[c] >= 0);
                end else begin
                    m_y[c]  = (m_i1[c] >= 0);
                end
            end
            exp_bits[c] = m_y[c];
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n_in = 1'b0; audio_valid_in = 1'b0; sample_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        model_reset();
    endtask

    // Starts at a negedge: one tick, then NCH+3 cycles so the period exceeds NCH+2.
    task automatic run_frame(output logic [NCH-1:0] pdm, output int fd_k, output int fd_n);
        sample_in = 1'b1;
        fd_k = -1; fd_n = 0; pdm = 'x;
        for (int k = 1; k <= NCH + 3; k++) begin
            @(negedge clk_in);
            if (k == 1) sample_in = 1'b0;
            if (frame_done_out) begin fd_n++; fd_k = k; end
            if (k == NCH + 2) pdm = pdm_out;
        end
    endtask

    task automatic send_word(input logic [NCH*BW-1:0] data);
        int n;
        audio_in = data; audio_valid_in = 1'b1; n = 0;
        while (!audio_ready_out && n < 50) begin @(negedge clk_in); n++; end
        @(negedge clk_in);
        audio_valid_in = 1'b0;
        m_pend.push_back(data);
        n_chk++;
        if (n < 50) n_pass++;
        else $display("FAIL send_timeout ready stayed %b, required 1", audio_ready_out);
    endtask

    task automatic test_reset();
        @(negedge clk_in);
        rst_n_in = 1'b0; audio_valid_in = 1'b1; audio_in = {$urandom, $urandom, $urandom};
        for (int i = 0; i < 12; i++) begin
            sample_in = ~sample_in;
            @(negedge clk_in);
            n_chk++;
            if (pdm_out !== '0 || frame_done_out !== 1'b0 || overrun_out !== 1'b0 || audio_ready_out !== 1'b1)
                $display("FAIL reset_hold cyc%0d pdm=%b fd=%b ovr=%b rdy=%b, required 0000/0/0/1",
                         i, pdm_out, frame_done_out, overrun_out, audio_ready_out);
            else n_pass++;
        end
        audio_valid_in = 1'b0; sample_in = 1'b0; rst_n_in = 1'b1;
        model_reset();
        @(negedge clk_in);
        n_chk++;
        if (audio_ready_out !== 1'b1 || pdm_out !== '0) $display("FAIL reset_release rdy=%b pdm=%b, required 1/0000", audio_ready_out, pdm_out);
        else n_pass++;
    endtask

    task automatic test_zero_order1();
        logic [NCH-1:0] got, exp_b, prev;
        int fk, fn, ones[NCH];
        bit alt_ok;
        do_reset();
        order_in = 1'b0; ch_en_in = '1; alt_ok = 1; prev = '0;
        for (int c = 0; c < NCH; c++) ones[c] = 0;
        for (int f = 0; f < 256; f++) begin
            model_tick(1'b0, ch_en_in, exp_b);
            run_frame(got, fk, fn);
            n_chk++;
            if (got !== exp_b || fk != NCH + 2 || fn != 1)
                $display("FAIL zero_frame%0d pdm=%b fd_at=%0d fd_n=%0d, required %b/%0d/1", f, got, fk, fn, exp_b, NCH + 2);
            else n_pass++;
            for (int c = 0; c < NCH; c++) ones[c] += int'(got[c]);
            if (f >= 2 && (got ^ prev) !== '1) alt_ok = 0;
            prev = got;
        end
        for (int c = 0; c < NCH; c++) begin
            n_chk++;
            if (ones[c] < 127 || ones[c] > 129) $display("FAIL zero_density ch%0d ones=%0d, required 128+-1", c, ones[c]);
            else n_pass++;
        end
        n_chk++;
        if (!alt_ok) $display("FAIL zero_alternate got non-alternating bits, required alternation");
        else n_pass++;
    endtask

    task automatic test_order2_density();
        logic [NCH-1:0] got, exp_b;
        int fk, fn, o0, o1, bad;
        do_reset();
        send_word({24'h000000, 24'h000000, 24'hC00000, 24'h3FFFFF});
        order_in = 1'b1; ch_en_in = '1; o0 = 0; o1 = 0; bad = 0;
        for (int f = 0; f < 1024; f++) begin
            model_tick(1'b1, ch_en_in, exp_b);
            run_frame(got, fk, fn);
            if (got !== exp_b || fk != NCH + 2 || fn != 1) bad++;
            o0 += int'(got[0]); o1 += int'(got[1]);
        end
        n_chk++;
        if (bad != 0) $display("FAIL ord2_frames %0d frames differ, required 0", bad); else n_pass++;
        n_chk++;
        if (o0 < 764 || o0 > 772) $display("FAIL ord2_ch0 ones=%0d, required 768+-4", o0); else n_pass++;
        n_chk++;
        if (o1 < 252 || o1 > 260) $display("FAIL ord2_ch1 ones=%0d, required 256+-4", o1); else n_pass++;
    endtask

    task automatic test_saturation();
        logic [NCH-1:0] got, exp_b;
        int fk, fn, bad, ones[NCH];
        do_reset();
        send_word({NCH{24'h7FFFFF}});
        order_in = 1'b1; ch_en_in = '1; bad = 0;
        for (int c = 0; c < NCH; c++) ones[c] = 0;
        for (int f = 0; f < 1024; f++) begin
            model_tick(1'b1, ch_en_in, exp_b);
            run_frame(got, fk, fn);
            if (got !== exp_b) bad++;
            for (int c = 0; c < NCH; c++) ones[c] += int'(got[c]);
        end
        n_chk++;
        if (bad != 0) $display("FAIL sat_frames %0d frames differ, required 0", bad); else n_pass++;
        for (int c = 0; c < NCH; c++) begin
            n_chk++;
            if (ones[c] < 1020) $display("FAIL sat_density ch%0d ones=%0d, required >=1020", c, ones[c]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [NCH*BW-1:0] a, b;
        logic [NCH-1:0] got, exp_b;
        int fk, fn;
        do_reset();
        a = {NCH{24'h300000}}; b = {NCH{24'hD00000}};
        order_in = 1'b0; ch_en_in = '1;
        send_word(a);
        audio_in = b; audio_valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            n_chk++;
            if (audio_ready_out !== 1'b0) $display("FAIL b2b_stall cyc%0d rdy=%b, required 0", i, audio_ready_out);
            else n_pass++;
        end
        model_tick(1'b0, ch_en_in, exp_b);
        sample_in = 1'b1; fk = -1; fn = 0;
        for (int k = 1; k <= NCH + 3; k++) begin
            @(negedge clk_in);
            if (k == 1) begin
                sample_in = 1'b0;
                n_chk++;
                if (audio_ready_out !== 1'b1) $display("FAIL b2b_free rdy=%b, required 1", audio_ready_out);
                else n_pass++;
            end
            if (k == 2) begin
                n_chk++;
                if (audio_ready_out !== 1'b0) $display("FAIL b2b_take rdy=%b, required 0", audio_ready_out);
                else n_pass++;
                audio_valid_in = 1'b0;
                m_pend.push_back(b);
            end
            if (frame_done_out) begin fn++; fk = k; end
            if (k == NCH + 2) got = pdm_out;
        end
        n_chk++;
        if (got !== exp_b || fk != NCH + 2 || fn != 1)
            $display("FAIL b2b_first pdm=%b fd_at=%0d, required %b/%0d", got, fk, exp_b, NCH + 2);
        else n_pass++;
        for (int f = 0; f < 3; f++) begin
            model_tick(1'b0, ch_en_in, exp_b);
            run_frame(got, fk, fn);
            n_chk++;
            if (got !== exp_b) $display("FAIL b2b_next%0d pdm=%b, required %b", f, got, exp_b);
            else n_pass++;
        end
    endtask

    task automatic test_overrun();
        int cyc, fd_cnt, fd_bad;
        bit fd_seen;
        do_reset();
        order_in = 1'b0; ch_en_in = '1;
        cyc = 0; fd_cnt = 0; fd_bad = 0;
        for (int i = 0; i < 10; i++) begin
            sample_in = 1'b1;
            for (int k = 0; k < NCH + 1; k++) begin
                @(negedge clk_in); cyc++;
                if (k == 0) sample_in = 1'b0;
                if (frame_done_out) begin fd_cnt++; if (cyc % 10 != 6) fd_bad++; end
                if (cyc == 5) begin
                    n_chk++;
                    if (overrun_out !== 1'b0) $display("FAIL ovr_early ovr=%b, required 0", overrun_out);
                    else n_pass++;
                end
            end
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in); cyc++;
            if (frame_done_out) begin fd_cnt++; if (cyc % 10 != 6) fd_bad++; end
        end
        n_chk++;
        if (overrun_out !== 1'b1) $display("FAIL ovr_sticky ovr=%b, required 1", overrun_out); else n_pass++;
        n_chk++;
        if (fd_cnt != 5 || fd_bad != 0) $display("FAIL ovr_pulses count=%0d misplaced=%0d, required 5/0", fd_cnt, fd_bad);
        else n_pass++;
        // Abort a frame mid-run with reset: no pulse, outputs back to reset values.
        sample_in = 1'b1;
        @(negedge clk_in); sample_in = 1'b0;
        @(negedge clk_in); rst_n_in = 1'b0;
        fd_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            if (k == 1) rst_n_in = 1'b1;
            if (frame_done_out) fd_seen = 1;
        end
        model_reset();
        n_chk++;
        if (fd_seen || overrun_out !== 1'b0 || pdm_out !== '0)
            $display("FAIL abort fd_seen=%0d ovr=%b pdm=%b, required 0/0/0000", fd_seen, overrun_out, pdm_out);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [NCH-1:0] got, exp_b;
        int fk, fn;
        bit ord;
        do_reset();
        ord = 1'b0;
        for (int f = 0; f < 300; f++) begin
            if ($urandom_range(0, 2) == 0) send_word({$urandom, $urandom, $urandom});
            if ($urandom_range(0, 7) == 0) ord = ~ord;
            order_in = ord;
            ch_en_in = NCH'($urandom) | NCH'($urandom);
            model_tick(ord, ch_en_in, exp_b);
            run_frame(got, fk, fn);
            order_in = 1'($urandom);
            ch_en_in = NCH'($urandom);
            n_chk++;
            if (got !== exp_b || fk != NCH + 2 || fn != 1)
                $display("FAIL rand_frame%0d pdm=%b fd_at=%0d fd_n=%0d, required %b/%0d/1", f, got, fk, fn, exp_b, NCH + 2);
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_zero_order1();
        test_order2_density();
        test_saturation();
        test_back_to_back();
        test_overrun();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
